// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and imem fetch front end with single-outstanding req/rvalid handshake
// Optional feature macro: MISALIGN_CHECK_EN (misaligned next PC traps into FAULT instead of being aligned)
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req/imem_addr           fetch request and address, held until imem_rvalid
//   imem_rvalid/imem_rdata       fetch response
//   instr_valid/instr_ready      instruction handshake towards decode
//   instr/pc_out/pc_plus4        fetched word, its PC and the link value
//   br_taken/jal/jalr            redirect controls, sampled at handshake
//   imm_val/rs1_val              immediate and JALR base operand
//   fetch_fault                  misaligned target trap indicator
module instr_fetch_unit #(
    parameter int PC_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [PC_W-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] pc_out,
    input  logic            br_taken,
    input  logic            jal,
    input  logic            jalr,
    input  logic [PC_W-1:0] imm_val,
    input  logic [PC_W-1:0] rs1_val,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fetch_fault
);
    typedef enum logic [1:0] {
`ifdef MISALIGN_CHECK_EN
        FAULT,
`endif
        IDLE,
        REQ,
        VALID
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_fetch_q, pc_fetch_d;
    logic [PC_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0] pc_out_q, pc_out_d;
    logic [PC_W-1:0] tgt;

    assign imem_req    = state_q == REQ;
    assign imem_addr   = pc_fetch_q;
    assign instr_valid = state_q == VALID;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + PC_W'(4);
`ifdef MISALIGN_CHECK_EN
    assign fetch_fault = state_q == FAULT;
`else
    assign fetch_fault = 1'b0;
`endif

    // jalr > jal/br_taken > sequential
    assign tgt = jalr ? ((rs1_val + imm_val) & ~PC_W'(1)) :
                 (jal | br_taken) ? pc_out_q + imm_val : pc_out_q + PC_W'(4);

    always_comb begin
        state_d    = state_q;
        pc_fetch_d = pc_fetch_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_rvalid) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_fetch_q;
                    state_d  = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
`ifdef MISALIGN_CHECK_EN
                    pc_fetch_d = tgt;
                    state_d    = |tgt[1:0] ? FAULT : REQ;
`else
                    pc_fetch_d = {tgt[PC_W-1:2], 2'b00};
                    state_d    = REQ;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_fetch_q <= RESET_PC;
            instr_q    <= PC_W'(32'h0000_0013);
            pc_out_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_fetch_q <= pc_fetch_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
        end
    end
endmodule
